seq_loader: RTL and testbench
=============================

SEQ_LOADER -- requirements
Module: seq_loader

Interface
REQ-001 Parameter: NBASES, 12, bases per sequence; the packed width is 2*NBASES.
REQ-002 Parameter: TIMEOUT, 128, maximum cycles spent waiting for acc_ready.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  8  ASCII character stream; the first NBASES valid bases are R, the next NBASES are Q.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  loader accepts in_data this cycle.
REQ-008 R  output  2*NBASES  packed reference sequence fed to bsw_acc.
REQ-009 Q  output  2*NBASES  packed query sequence fed to bsw_acc.
REQ-010 acc_start  output  1  one-cycle start pulse to bsw_acc.
REQ-011 acc_ready  input  1  completion flag from bsw_acc.
REQ-012 busy  output  1  high in every state except LOAD_R with a zero count.
REQ-013 err_char  output  1  one-cycle pulse when an invalid character is consumed.
REQ-014 err_timeout  output  1  sticky flag; cleared by the next accepted base.

Function
REQ-015 A byte transfers when in_valid and in_ready are both high in the same cycle.
REQ-016 Decode rule: 'A'/'a' -> 0, 'T'/'t' -> 1, 'G'/'g' -> 2, 'C'/'c' -> 3.
REQ-017 0x0A, 0x0D and 0x20 are consumed and ignored; no count change and no error.
REQ-018 Any other byte is consumed and dropped, err_char pulses the next cycle, and the count is unchanged.
REQ-019 Packing is MSB-first: base k of a sequence (k = 0..NBASES-1) occupies bits [2*NBASES-1-2k : 2*NBASES-2-2k].
REQ-020 FSM states: LOAD_R, LOAD_Q, START, WAIT.
REQ-021 Transitions:
- LOAD_R -> LOAD_Q on the NBASES-th valid base;
- LOAD_Q -> START on the NBASES-th valid base;
- START -> WAIT unconditionally after 1 cycle;
- WAIT -> LOAD_R on a 0->1 edge of acc_ready;
- WAIT -> LOAD_R on timeout.
REQ-022 in_ready is high only in LOAD_R and LOAD_Q.
REQ-023 acc_start is high only during the single START cycle.
REQ-024 R and Q hold stable from entry to START until the next LOAD_R base write.
REQ-025 Base counter: ceil(log2(NBASES+1)) bits; clears to 0 on each LOAD_R/LOAD_Q exit; never wraps past NBASES.
REQ-026 The acc_ready edge is detected only from the cycle after START; a level high at START entry, left from a previous job, is ignored.
REQ-027 WAIT cycle counter: starts at 0 on WAIT entry; on reaching TIMEOUT-1 with no acc_ready edge, sets err_timeout and returns to LOAD_R.
REQ-028 If the acc_ready edge and timeout coincide, the edge wins and err_timeout is not set.
REQ-029 Back-to-back streaming: the base completing Q is the last byte accepted; in_ready is low from START until the LOAD_R cycle after WAIT exits.

Reset
REQ-030 Asserting reset_n low, including mid-load or mid-WAIT, immediately forces:
- state to LOAD_R;
- R, Q, base count and WAIT count to 0;
- acc_start, err_char and err_timeout to 0;
- busy to 0 and in_ready to 1 after release.
REQ-031 A partially loaded sequence is discarded on reset; no acc_start is issued for it.

Structure
REQ-032 Shared package seq_pkg holds:
- base encoding constants BASE_A=0, BASE_T=1, BASE_G=2, BASE_C=3;
- the FSM state type;
- the NBASES default.
REQ-033 One sub-module, base_decode: combinational ASCII -> {valid, ignore, code[1:0]}, instanced once in seq_loader.

Verification
REQ-034 Stream "TGCTATAACAGA" then "TGATAATGCAGA" -> R = 24'h6d10c8, Q = 24'h6106c8, acc_start pulses exactly 1 cycle.
REQ-035 Same stream in lowercase with "\r\n" and spaces interleaved -> identical R/Q, err_char never asserted.
REQ-036 Byte 'N' inserted after base 5 of R -> err_char pulses once, and R still equals 24'h6d10c8 once 12 valid bases arrive.
REQ-037 acc_ready held high before START and kept high throughout -> no edge detected, err_timeout set at WAIT cycle 128, FSM returns to LOAD_R.
REQ-038 reset_n pulsed low after 7 R bases -> R = 0, count = 0, no acc_start; a following full 24-base stream loads correctly.
REQ-039 in_valid toggled randomly across two consecutive jobs, with acc_ready rising 40 cycles after start -> two acc_start pulses with the correct R/Q each, in_ready low during START/WAIT.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the sequence loader: base codes, FSM state,
// and the decoded-character payload.
package seq_pkg;

  localparam int unsigned NBASES_DEF = 12;

  localparam logic [1:0] BASE_A = 2'd0;
  localparam logic [1:0] BASE_T = 2'd1;
  localparam logic [1:0] BASE_G = 2'd2;
  localparam logic [1:0] BASE_C = 2'd3;

  typedef enum logic [1:0] {
    LOAD_R = 2'd0,
    LOAD_Q = 2'd1,
    START  = 2'd2,
    WAIT   = 2'd3
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       ignore;
    logic [1:0] code;
  } dec_t;

endpackage

// File: rtl/base_decode.sv
// ASCII to 2-bit base decoder; flags whitespace as ignorable and anything
// else that is not a base as invalid (valid and ignore both low).
module base_decode
  import seq_pkg::*;
(
  input  logic [7:0] i_char,
  output dec_t       o_dec_c
);

  always_comb begin
    o_dec_c = '0;
    case (i_char)
      8'h41, 8'h61: begin
        o_dec_c.valid = 1'b1;
        o_dec_c.code  = BASE_A;
      end
      8'h54, 8'h74: begin
        o_dec_c.valid = 1'b1;
        o_dec_c.code  = BASE_T;
      end
      8'h47, 8'h67: begin
        o_dec_c.valid = 1'b1;
        o_dec_c.code  = BASE_G;
      end
      8'h43, 8'h63: begin
        o_dec_c.valid = 1'b1;
        o_dec_c.code  = BASE_C;
      end
      8'h0A, 8'h0D, 8'h20: o_dec_c.ignore = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_loader.sv
// Streams ASCII bases into packed R/Q registers, kicks the aligner with a
// one-cycle start pulse and waits (with timeout) for its completion edge.
module seq_loader
  import seq_pkg::*;
#(
  parameter int unsigned NBASES  = NBASES_DEF,
  parameter int unsigned TIMEOUT = 128
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [2*NBASES-1:0] R,
  output logic [2*NBASES-1:0] Q,
  output logic                acc_start,
  input  logic                acc_ready,
  output logic                busy,
  output logic                err_char,
  output logic                err_timeout
);

  localparam int unsigned SEQ_W  = 2 * NBASES;
  localparam int unsigned CNT_W  = $clog2(NBASES + 1);
  localparam int unsigned WCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [WCNT_W-1:0]  r_wcnt;
  logic [WCNT_W-1:0]  w_wcnt_nxt;
  logic [SEQ_W-1:0]   r_r;
  logic [SEQ_W-1:0]   r_q;
  logic [SEQ_W-1:0]   w_r_nxt;
  logic [SEQ_W-1:0]   w_q_nxt;
  logic               r_in_ready;
  logic               r_acc_start;
  logic               r_busy;
  logic               r_err_char;
  logic               r_err_timeout;
  logic               r_acc_ready_q;
  logic               w_in_ready_nxt;
  logic               w_acc_start_nxt;
  logic               w_busy_nxt;
  logic               w_err_char_nxt;
  logic               w_err_to_nxt;

  dec_t               w_dec;
  logic               w_fire;
  logic               w_base;
  logic               w_last;
  logic               w_edge;
  logic               w_wait_done;
  int unsigned        w_shift;
  logic [SEQ_W-1:0]   w_base_mask;
  logic [SEQ_W-1:0]   w_base_val;

  base_decode u_base_decode (
    .i_char  (in_data),
    .o_dec_c (w_dec)
  );

  assign w_fire      = in_valid & r_in_ready;
  assign w_base      = w_fire & w_dec.valid;
  assign w_last      = (r_cnt == CNT_W'(NBASES - 1));
  assign w_edge      = acc_ready & ~r_acc_ready_q;
  assign w_wait_done = (r_wcnt == WCNT_W'(TIMEOUT - 1));

  // Base k lands MSB-first, so its field sits 2*(NBASES-1-k) bits up.
  assign w_shift     = 2 * (NBASES - 1) - 2 * 32'(r_cnt);
  assign w_base_mask = SEQ_W'(2'b11) << w_shift;
  assign w_base_val  = SEQ_W'(w_dec.code) << w_shift;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= LOAD_R;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_wcnt_nxt     = r_wcnt;
    w_r_nxt        = r_r;
    w_q_nxt        = r_q;
    w_err_char_nxt = w_fire & ~w_dec.valid & ~w_dec.ignore;
    w_err_to_nxt   = r_err_timeout & ~w_base;

    case (r_state)
      LOAD_R: begin
        if (w_base) begin
          w_r_nxt = (r_r & ~w_base_mask) | w_base_val;
          if (w_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = LOAD_Q;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      LOAD_Q: begin
        if (w_base) begin
          w_q_nxt = (r_q & ~w_base_mask) | w_base_val;
          if (w_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = START;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      START: begin
        w_wcnt_nxt  = '0;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        // A completion edge takes priority over a coincident timeout.
        if (w_edge) begin
          w_wcnt_nxt  = '0;
          w_state_nxt = LOAD_R;
        end else if (w_wait_done) begin
          w_wcnt_nxt   = '0;
          w_err_to_nxt = 1'b1;
          w_state_nxt  = LOAD_R;
        end else begin
          w_wcnt_nxt = r_wcnt + WCNT_W'(1);
        end
      end
      default: w_state_nxt = LOAD_R;
    endcase

    w_in_ready_nxt  = (w_state_nxt == LOAD_R) || (w_state_nxt == LOAD_Q);
    w_acc_start_nxt = (w_state_nxt == START);
    w_busy_nxt      = !((w_state_nxt == LOAD_R) && (w_cnt_nxt == '0));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt         <= '0;
      r_wcnt        <= '0;
      r_r           <= '0;
      r_q           <= '0;
      r_in_ready    <= 1'b1;
      r_acc_start   <= 1'b0;
      r_busy        <= 1'b0;
      r_err_char    <= 1'b0;
      r_err_timeout <= 1'b0;
      r_acc_ready_q <= 1'b0;
    end else begin
      r_cnt         <= w_cnt_nxt;
      r_wcnt        <= w_wcnt_nxt;
      r_r           <= w_r_nxt;
      r_q           <= w_q_nxt;
      r_in_ready    <= w_in_ready_nxt;
      r_acc_start   <= w_acc_start_nxt;
      r_busy        <= w_busy_nxt;
      r_err_char    <= w_err_char_nxt;
      r_err_timeout <= w_err_to_nxt;
      r_acc_ready_q <= acc_ready;
    end
  end

  assign in_ready    = r_in_ready;
  assign R           = r_r;
  assign Q           = r_q;
  assign acc_start   = r_acc_start;
  assign busy        = r_busy;
  assign err_char    = r_err_char;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_seq_loader.sv
// Directed self-checking bench for seq_loader: load, decode, error, timeout,
// reset and back-to-back job scenarios.
`timescale 1ns/1ps
module tb_seq_loader;

  localparam int unsigned NB  = 12;
  localparam int unsigned TMO = 128;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [7:0]      in_data = 8'h00;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2*NB-1:0] R;
  logic [2*NB-1:0] Q;
  logic            acc_start;
  logic            acc_ready = 1'b0;
  logic            busy;
  logic            err_char;
  logic            err_timeout;

  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;
  int n_errc   = 0;
  int n_rdy_st = 0;

  seq_loader #(.NBASES(NB), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .R           (R),
    .Q           (Q),
    .acc_start   (acc_start),
    .acc_ready   (acc_ready),
    .busy        (busy),
    .err_char    (err_char),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (acc_start) n_start++;
    if (err_char) n_errc++;
    if (acc_start && in_ready) n_rdy_st++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      n_checks++; n_fail++;
      $display("FAIL send_byte: in_ready stayed %b for %0d cycles, required 1", in_ready, n);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s, input int maxgap);
    for (int i = 0; i < s.len(); i++)
      send_byte(s[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (!acc_start && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL wait_start: acc_start=%b after %0d cycles, required 1", acc_start, n);
    end
  endtask

  task automatic finish_job(input int delay);
    int bad;
    int n;
    bad = 0;
    for (int i = 0; i < delay; i++) begin
      tick();
      if (in_ready) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL wait_in_ready: in_ready high in %0d WAIT cycles, required 0", bad); end
    acc_ready = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL job_done: in_ready=%b, required 1", in_ready); end
    acc_ready = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: busy=%b, required 0", busy); end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    in_valid  = 1'b0;
    acc_ready = 1'b0;
    reset_n   = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (R !== 24'h0) begin n_fail++; $display("FAIL reset_R: got %h, required 000000", R); end
    n_checks++;
    if (Q !== 24'h0) begin n_fail++; $display("FAIL reset_Q: got %h, required 000000", Q); end
    n_checks++;
    if ({acc_start, err_char, err_timeout} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b, required 000", {acc_start, err_char, err_timeout});
    end
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
  endtask

  task automatic test_basic();
    int s0;
    int e0;
    s0 = n_start;
    e0 = n_errc;
    send_str("TGCTATAACAGA", 0);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_q: got %b, required 1", busy); end
    send_str("TGATAATGCAGA", 0);
    wait_start();
    n_checks++;
    if (R !== 24'h6d10c8) begin n_fail++; $display("FAIL basic_R: got %h, required 6d10c8", R); end
    n_checks++;
    if (Q !== 24'h6106c8) begin n_fail++; $display("FAIL basic_Q: got %h, required 6106c8", Q); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_start_ready: got %b, required 0", in_ready); end
    finish_job(10);
    n_checks++;
    if (n_start - s0 !== 1) begin n_fail++; $display("FAIL basic_start_cycles: got %0d, required 1", n_start - s0); end
    n_checks++;
    if (n_errc - e0 !== 0) begin n_fail++; $display("FAIL basic_err_char: got %0d, required 0", n_errc - e0); end
  endtask

  task automatic test_lowercase_ws();
    int e0;
    e0 = n_errc;
    send_str("tgct a\r\ntaa caga\r\n", 0);
    send_str(" tga\r\ntaa tgc aga", 0);
    wait_start();
    n_checks++;
    if (R !== 24'h6d10c8) begin n_fail++; $display("FAIL lc_R: got %h, required 6d10c8", R); end
    n_checks++;
    if (Q !== 24'h6106c8) begin n_fail++; $display("FAIL lc_Q: got %h, required 6106c8", Q); end
    finish_job(5);
    n_checks++;
    if (n_errc - e0 !== 0) begin n_fail++; $display("FAIL lc_err_char: got %0d, required 0", n_errc - e0); end
  endtask

  task automatic test_bad_char();
    int e0;
    e0 = n_errc;
    send_str("TGCTANTAACAGA", 0);
    send_str("TGATAATGCAGA", 0);
    wait_start();
    n_checks++;
    if (n_errc - e0 !== 1) begin n_fail++; $display("FAIL bad_err_char: pulses %0d, required 1", n_errc - e0); end
    n_checks++;
    if (R !== 24'h6d10c8) begin n_fail++; $display("FAIL bad_R: got %h, required 6d10c8", R); end
    n_checks++;
    if (Q !== 24'h6106c8) begin n_fail++; $display("FAIL bad_Q: got %h, required 6106c8", Q); end
    finish_job(3);
  endtask

  task automatic test_timeout();
    int s0;
    int n;
    s0 = n_start;
    acc_ready = 1'b1;
    tick();
    send_str("TGCTATAACAGA", 0);
    send_str("TGATAATGCAGA", 0);
    wait_start();
    n = 0;
    while (!in_ready && n < 300) begin
      tick();
      n++;
    end
    n_checks++;
    if (n !== int'(TMO) + 1) begin n_fail++; $display("FAIL timeout_cycles: returned after %0d cycles, required %0d", n, TMO + 1); end
    n_checks++;
    if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_flag: got %b, required 1", err_timeout); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b, required 0", busy); end
    n_checks++;
    if (n_start - s0 !== 1) begin n_fail++; $display("FAIL timeout_start: got %0d, required 1", n_start - s0); end
    acc_ready = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b, required 1", err_timeout); end
    send_byte("A", 0);
    n_checks++;
    if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_clear: got %b, required 0", err_timeout); end
    apply_reset();
  endtask

  task automatic test_reset_mid();
    int s0;
    s0 = n_start;
    send_str("TGCTATA", 0);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b, required 1", busy); end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (R !== 24'h0) begin n_fail++; $display("FAIL mid_reset_R: got %h, required 000000", R); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b, required 0", busy); end
    tick();
    reset_n = 1'b1;
    repeat (20) tick();
    n_checks++;
    if (n_start - s0 !== 0) begin n_fail++; $display("FAIL mid_no_start: got %0d, required 0", n_start - s0); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b, required 1", in_ready); end
    send_str("TGCTATAACAGA", 0);
    send_str("TGATAATGCAGA", 0);
    wait_start();
    n_checks++;
    if (R !== 24'h6d10c8) begin n_fail++; $display("FAIL mid_R: got %h, required 6d10c8", R); end
    n_checks++;
    if (Q !== 24'h6106c8) begin n_fail++; $display("FAIL mid_Q: got %h, required 6106c8", Q); end
    finish_job(5);
  endtask

  task automatic test_back_to_back();
    int s0;
    s0 = n_start;
    send_str("TGCTATAACAGA", 2);
    send_str("TGATAATGCAGA", 2);
    wait_start();
    n_checks++;
    if (R !== 24'h6d10c8) begin n_fail++; $display("FAIL b2b_R1: got %h, required 6d10c8", R); end
    n_checks++;
    if (Q !== 24'h6106c8) begin n_fail++; $display("FAIL b2b_Q1: got %h, required 6106c8", Q); end
    finish_job(40);
    send_str("AAAACCCCGGGG", 2);
    n_checks++;
    if (Q !== 24'h6106c8) begin n_fail++; $display("FAIL b2b_Q_hold: got %h, required 6106c8", Q); end
    send_str("TTTTTTTTTTTT", 2);
    wait_start();
    n_checks++;
    if (R !== 24'h00ffaa) begin n_fail++; $display("FAIL b2b_R2: got %h, required 00ffaa", R); end
    n_checks++;
    if (Q !== 24'h555555) begin n_fail++; $display("FAIL b2b_Q2: got %h, required 555555", Q); end
    finish_job(40);
    n_checks++;
    if (n_start - s0 !== 2) begin n_fail++; $display("FAIL b2b_starts: got %0d, required 2", n_start - s0); end
    n_checks++;
    if (n_rdy_st !== 0) begin n_fail++; $display("FAIL b2b_ready_at_start: got %0d, required 0", n_rdy_st); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lowercase_ws();
    test_bad_char();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
